// File: rtl/controller_sequencer_if.sv
// Bundle between the controller-sequencer and the bus-attached datapath stages:
// the decoded IR opcode in, the control word, ring state and halt flag out.
interface controller_sequencer_if;
    logic [3:0] opcode;
    logic       cp;
    logic       ep;
    logic       lm;
    logic       ce;
    logic       li;
    logic       ei;
    logic       la;
    logic       ea;
    logic       su;
    logic       eu;
    logic       lb;
    logic       lo;
    logic [5:0] t_state;
    logic       halt;

    modport master (
        input  opcode,
        output cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo,
        output t_state, halt
    );

    modport slave (
        output opcode,
        input  cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo,
        input  t_state, halt
    );
endinterface

// File: rtl/controller_sequencer.sv
// SAP-1 controller-sequencer: six-state one-hot ring (fetch T1-T3, execute T4-T6)
// decoding the IR opcode into the datapath control word, with a sticky HLT state.
//
// state  | meaning
// T1     | PC onto bus, load MAR
// T2     | increment PC
// T3     | RAM onto bus, load IR
// T4     | execute step 1 (operand address / output); HLT exits to HALTED
// T5     | execute step 2 (memory operand fetch)
// T6     | execute step 3 (ALU result to accumulator)
// HALTED | all controls low, halt high; left only by clear
module controller_sequencer (
    input  logic clk,
    input  logic clear,
    controller_sequencer_if.master bus
);
    localparam logic [3:0] LDA_OP = 4'h0;
    localparam logic [3:0] ADD_OP = 4'h1;
    localparam logic [3:0] SUB_OP = 4'h2;
    localparam logic [3:0] OUT_OP = 4'hE;
    localparam logic [3:0] HLT_OP = 4'hF;

    // Low six bits are the ring itself, so t_state is a direct slice.
    typedef enum logic [6:0] {
        T1     = 7'b000_0001,
        T2     = 7'b000_0010,
        T3     = 7'b000_0100,
        T4     = 7'b000_1000,
        T5     = 7'b001_0000,
        T6     = 7'b010_0000,
        HALTED = 7'b100_0000
    } state_t;

    state_t state;
    state_t next_state;

    logic cp;
    logic ep;
    logic lm;
    logic ce;
    logic li;
    logic ei;
    logic la;
    logic ea;
    logic su;
    logic eu;
    logic lb;
    logic lo;

    always_ff @(posedge clk) begin
        if (clear) begin
            state <= T1;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        cp = 1'b0;
        ep = 1'b0;
        lm = 1'b0;
        ce = 1'b0;
        li = 1'b0;
        ei = 1'b0;
        la = 1'b0;
        ea = 1'b0;
        su = 1'b0;
        eu = 1'b0;
        lb = 1'b0;
        lo = 1'b0;

        unique case (state)
            T1: begin
                ep = 1'b1;
                lm = 1'b1;
                next_state = T2;
            end
            T2: begin
                cp = 1'b1;
                next_state = T3;
            end
            T3: begin
                ce = 1'b1;
                li = 1'b1;
                next_state = T4;
            end
            T4: begin
                case (bus.opcode)
                    LDA_OP, ADD_OP, SUB_OP: begin
                        ei = 1'b1;
                        lm = 1'b1;
                    end
                    OUT_OP: begin
                        ea = 1'b1;
                        lo = 1'b1;
                    end
                    default: ;
                endcase
                next_state = (bus.opcode == HLT_OP) ? HALTED : T5;
            end
            T5: begin
                case (bus.opcode)
                    LDA_OP: begin
                        ce = 1'b1;
                        la = 1'b1;
                    end
                    ADD_OP, SUB_OP: begin
                        ce = 1'b1;
                        lb = 1'b1;
                    end
                    default: ;
                endcase
                next_state = T6;
            end
            T6: begin
                if (bus.opcode == ADD_OP || bus.opcode == SUB_OP) begin
                    eu = 1'b1;
                    la = 1'b1;
                    su = (bus.opcode == SUB_OP);
                end
                next_state = T1;
            end
            HALTED: begin
                next_state = HALTED;
            end
            // Corrupted one-hot encodings fall back into the fetch ring.
            default: begin
                next_state = T1;
            end
        endcase
    end

    assign bus.cp      = cp;
    assign bus.ep      = ep;
    assign bus.lm      = lm;
    assign bus.ce      = ce;
    assign bus.li      = li;
    assign bus.ei      = ei;
    assign bus.la      = la;
    assign bus.ea      = ea;
    assign bus.su      = su;
    assign bus.eu      = eu;
    assign bus.lb      = lb;
    assign bus.lo      = lo;
    assign bus.t_state = state[5:0];
    assign bus.halt    = (state == HALTED);
endmodule
